// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared control-instruction definitions for the accumulator CPU. It holds
// the opcode encodings, the accumulator source and ALU op codes, the
// sequencer FSM state encodings and the next-pc select codes.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN adds the HALT state.
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

  // Opcode field of the 24-bit instruction word {opcode[7:0], operand[15:0]}
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_ST  = 8'h02;
  localparam logic [7:0] OP_LD  = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_INC = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_RST = 8'h07;

  // Accumulator write source
  localparam logic [1:0] ACC_SEL_IMM = 2'd0;
  localparam logic [1:0] ACC_SEL_RAM = 2'd1;
  localparam logic [1:0] ACC_SEL_ALU = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_OP_PASS = 2'd0;
  localparam logic [1:0] ALU_OP_ADD  = 2'd1;
  localparam logic [1:0] ALU_OP_INC  = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    ST_HALT     = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JMP  = 2'd2,
    PC_ZERO = 2'd3
  } pc_sel_t;

  // Instructions that perform a data RAM access
  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// ---------------------------------------------------------------------------
// instr_sequencer_decode
// Combinational decode of FSM state + latched opcode + RAM handshake into
// the datapath/RAM strobes, the next-pc select and the next FSM state.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (unknown opcode -> HALT).
// Ports:
//   i_state       current FSM state (state_t encoding)
//   i_opcode      opcode field of the instruction register
//   i_mem_ready   data RAM handshake
//   o_ram_req     data RAM request
//   o_ram_we      data RAM write qualifier
//   o_acc_we      accumulator write enable
//   o_acc_sel     accumulator source select
//   o_alu_op      ALU operation
//   o_pc_sel      next-pc select (pc_sel_t encoding)
//   o_next_state  next FSM state (state_t encoding)
//   o_illegal     unknown opcode seen in EXEC (trap build only)
// ---------------------------------------------------------------------------
module instr_sequencer_decode
  import instr_sequencer_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [7:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_ram_req,
  output logic       o_ram_we,
  output logic       o_acc_we,
  output logic [1:0] o_acc_sel,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_sel,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic       o_illegal,
`endif
  output logic [1:0] o_next_state
);

  logic w_mem_phase;

  // The RAM request spans the EXEC cycle of a memory op plus any wait cycles
  assign w_mem_phase = ((i_state == ST_EXEC) && is_mem_op(i_opcode)) ||
                       (i_state == ST_MEM_WAIT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    o_ram_req    = 1'b0;
    o_ram_we     = 1'b0;
    o_acc_we     = 1'b0;
    o_acc_sel    = ACC_SEL_IMM;
    o_alu_op     = ALU_OP_PASS;
    o_pc_sel     = PC_HOLD;
    o_next_state = i_state;
`ifdef SEQ_ILLEGAL_TRAP_EN
    o_illegal    = 1'b0;
`endif

    case (i_state)
      ST_FETCH: o_next_state = ST_EXEC;
      ST_EXEC: begin
        o_next_state = ST_FETCH;
        o_pc_sel     = PC_INC;
        case (i_opcode)
          OP_NOP: ;
          OP_LDI: begin
            o_acc_we  = 1'b1;
            o_acc_sel = ACC_SEL_IMM;
          end
          OP_INC: begin
            o_acc_we  = 1'b1;
            o_acc_sel = ACC_SEL_ALU;
            o_alu_op  = ALU_OP_INC;
          end
          OP_JMP: o_pc_sel = PC_JMP;
          OP_RST: o_pc_sel = PC_ZERO;
          OP_LD, OP_ADD, OP_ST: ;  // handled by the memory phase below
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            o_next_state = ST_HALT;
            o_pc_sel     = PC_HOLD;
            o_illegal    = 1'b1;
`else
            // Unknown opcodes behave as NOP
            o_pc_sel     = PC_INC;
`endif
          end
        endcase
      end
      ST_MEM_WAIT: ;
`ifdef SEQ_ILLEGAL_TRAP_EN
      ST_HALT: ;  // stays put with no strobes until reset
`endif
      default: o_next_state = ST_FETCH;
    endcase

    if (w_mem_phase) begin
      o_ram_req = 1'b1;
      o_ram_we  = (i_opcode == OP_ST);
      if (i_mem_ready) begin
        // Completing cycle: load the accumulator (LD/ADD) and advance
        if (i_opcode == OP_LD) begin
          o_acc_we  = 1'b1;
          o_acc_sel = ACC_SEL_RAM;
        end else if (i_opcode == OP_ADD) begin
          o_acc_we  = 1'b1;
          o_acc_sel = ACC_SEL_ALU;
          o_alu_op  = ALU_OP_ADD;
        end
        o_pc_sel     = PC_INC;
        o_next_state = ST_FETCH;
      end else begin
        o_pc_sel     = PC_HOLD;
        o_next_state = ST_MEM_WAIT;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Fetch/decode/execute controller for the accumulator CPU. Owns the program
// counter (sole master of the ROM address), latches the instruction word and
// issues strobes to the accumulator/ALU datapath and the data RAM.
// FSM: FETCH -> EXEC -> (MEM_WAIT) -> FETCH.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN adds HALT and illegal_op.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rom_addr     instruction ROM address (= pc)
//   rom_data     instruction word {opcode, operand} from ROM
//   mem_ready    data RAM handshake
//   ram_req/we   data RAM request / write qualifier
//   ram_addr     data RAM address (= IR operand)
//   imm          immediate operand (= IR operand)
//   acc_we       accumulator write enable
//   acc_sel      accumulator source (IMM/RAM/ALU)
//   alu_op       ALU op (PASS/ADD/INC)
//   pc           program counter (debug)
//   illegal_op   sticky unknown-opcode flag (trap build only)
//   busy         high whenever the FSM is not in FETCH
// ---------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_WIDTH        = 4,
  parameter int WORD_WIDTH      = 24,
  parameter int DATA_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [PC_WIDTH-1:0]        rom_addr,
  input  logic [WORD_WIDTH-1:0]      rom_data,
  input  logic                       mem_ready,
  output logic                       ram_req,
  output logic                       ram_we,
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]                imm,
  output logic                       acc_we,
  output logic [1:0]                 acc_sel,
  output logic [1:0]                 alu_op,
  output logic [PC_WIDTH-1:0]        pc,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic                       illegal_op,
`endif
  output logic                       busy
);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [WORD_WIDTH-1:0] r_ir;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic                  r_illegal;
  logic                  w_illegal;
`endif

  logic [7:0]  w_opcode;
  logic [15:0] w_operand;
  logic [1:0]  w_pc_sel;
  logic [1:0]  w_next_state;

  assign w_opcode  = r_ir[WORD_WIDTH-1 -: 8];
  assign w_operand = r_ir[15:0];

  instr_sequencer_decode u_decode (
    .i_state      (r_state),
    .i_opcode     (w_opcode),
    .i_mem_ready  (mem_ready),
    .o_ram_req    (ram_req),
    .o_ram_we     (ram_we),
    .o_acc_we     (acc_we),
    .o_acc_sel    (acc_sel),
    .o_alu_op     (alu_op),
    .o_pc_sel     (w_pc_sel),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .o_illegal    (w_illegal),
`endif
    .o_next_state (w_next_state)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the IR is reset as well because imm and ram_addr are driven
      // straight from it and must read 0 out of reset.
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= state_t'(w_next_state);
      if (r_state == ST_FETCH) begin
        r_ir <= rom_data;
      end
      case (pc_sel_t'(w_pc_sel))
        PC_INC:  r_pc <= r_pc + PC_WIDTH'(1);  // wraps silently
        PC_JMP:  r_pc <= w_operand[PC_WIDTH-1:0];
        PC_ZERO: r_pc <= '0;
        default: r_pc <= r_pc;
      endcase
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (w_illegal) begin
        r_illegal <= 1'b1;
      end
`endif
    end
  end

  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign ram_addr = w_operand[DATA_ADDR_WIDTH-1:0];
  assign imm      = w_operand;
  assign busy     = (r_state != ST_FETCH);
`ifdef SEQ_ILLEGAL_TRAP_EN
  assign illegal_op = r_illegal;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. Each program's expected per-cycle
// outputs (and the mem_ready/rst stimulus for that cycle) are pushed to a
// scoreboard queue when the program is loaded, then drained one clock at a
// time, sampling the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  typedef struct packed {
    logic [3:0]  pc;
    logic [3:0]  rom_addr;
    logic        busy;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic        acc_we;
    logic [1:0]  acc_sel;
    logic [1:0]  alu_op;
    logic [15:0] imm;
    logic        ill;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
    logic  full;  // compare imm/ram_addr even when not in use
    logic  rdy;
    logic  rs;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic [3:0]  rom_addr;
  logic [23:0] rom_data;
  logic        ram_req, ram_we, acc_we, busy;
  logic [15:0] ram_addr, imm;
  logic [1:0]  acc_sel, alu_op;
  logic [3:0]  pc;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  logic [23:0] rom [16];
  entry_t      scb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .mem_ready (mem_ready),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .imm       (imm),
    .acc_we    (acc_we),
    .acc_sel   (acc_sel),
    .alu_op    (alu_op),
    .pc        (pc),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .busy      (busy)
  );

  function automatic void push(string tag, logic rdy, logic rs, int pcv,
                               logic bsy, logic rq, logic we, int ra,
                               logic awe, int asel, int aop, int immv,
                               logic full, logic ill);
    entry_t e;
    e.v.pc       = 4'(pcv);
    e.v.rom_addr = 4'(pcv);
    e.v.busy     = bsy;
    e.v.ram_req  = rq;
    e.v.ram_we   = we;
    e.v.ram_addr = 16'(ra);
    e.v.acc_we   = awe;
    e.v.acc_sel  = 2'(asel);
    e.v.alu_op   = 2'(aop);
    e.v.imm      = 16'(immv);
    e.v.ill      = ill;
    e.tag  = tag;
    e.full = full;
    e.rdy  = rdy;
    e.rs   = rs;
    scb_q.push_back(e);
  endfunction

  // Cycle with no strobes at all
  function automatic void quiet(string tag, int pcv, logic bsy, logic rdy);
    push(tag, rdy, 1'b0, pcv, bsy, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endfunction

  // Cycle right after a reset edge: everything zero, data fields included
  function automatic void reset_state(string tag, logic rdy);
    push(tag, rdy, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = {OP_NOP, 16'h0000};
  endtask

  // One clock per scoreboard entry: drive, sample on falling edge, compare
  task automatic drain();
    entry_t e;
    obs_t   o;
    while (scb_q.size() > 0) begin
      e = scb_q.pop_front();
      rst       = e.rs;
      mem_ready = e.rdy;
      @(negedge clk);
      o.pc       = pc;
      o.rom_addr = rom_addr;
      o.busy     = busy;
      o.ram_req  = ram_req;
      o.ram_we   = ram_we;
      o.ram_addr = ram_addr;
      o.acc_we   = acc_we;
      o.acc_sel  = acc_sel;
      o.alu_op   = alu_op;
      o.imm      = imm;
`ifdef SEQ_ILLEGAL_TRAP_EN
      o.ill      = illegal_op;
`else
      o.ill      = 1'b0;
`endif
      // imm / ram_addr only carry meaning when the strobe that uses them is on
      if (!e.full && !e.v.ram_req) o.ram_addr = e.v.ram_addr;
      if (!e.full && !(e.v.acc_we && e.v.acc_sel == ACC_SEL_IMM)) o.imm = e.v.imm;
      n_checks++;
      assert (o === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ---- Program A: NOP, LDI, ST with waits, ADD, LD, JMP, INC loop ----
    clear_rom();
    rom[0]  = {OP_NOP, 16'h0000};
    rom[1]  = {OP_LDI, 16'h0005};
    rom[2]  = {OP_ST,  16'h0001};
    rom[3]  = {OP_ADD, 16'h0001};
    rom[4]  = {OP_LD,  16'h0002};
    rom[5]  = {OP_JMP, 16'h001A};
    rom[9]  = {OP_INC, 16'h0000};
    rom[10] = {OP_JMP, 16'h0009};
    do_reset();
    reset_state("reset_a", 1'b1);
    quiet("nop_exec", 0, 1, 1'b1);
    quiet("fetch_1", 1, 0, 1'b1);
    push("ldi_5", 1'b1, 1'b0, 1, 1, 0, 0, 0, 1, ACC_SEL_IMM, ALU_OP_PASS, 5, 1'b0, 1'b0);
    quiet("fetch_2", 2, 0, 1'b1);
    push("st_exec",  1'b0, 1'b0, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    push("st_wait1", 1'b0, 1'b0, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    push("st_wait2", 1'b0, 1'b0, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    push("st_ready", 1'b1, 1'b0, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    quiet("fetch_3", 3, 0, 1'b1);
    push("add_1", 1'b1, 1'b0, 3, 1, 1, 0, 1, 1, ACC_SEL_ALU, ALU_OP_ADD, 0, 1'b0, 1'b0);
    quiet("fetch_4", 4, 0, 1'b1);
    push("ld_2", 1'b1, 1'b0, 4, 1, 1, 0, 2, 1, ACC_SEL_RAM, ALU_OP_PASS, 0, 1'b0, 1'b0);
    quiet("fetch_5", 5, 0, 1'b1);
    quiet("jmp_1a", 5, 1, 1'b1);
    quiet("fetch_10", 10, 0, 1'b1);
    quiet("jmp_9", 10, 1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      quiet("fetch_9", 9, 0, 1'b1);
      push("inc", 1'b1, 1'b0, 9, 1, 0, 0, 0, 1, ACC_SEL_ALU, ALU_OP_INC, 0, 1'b0, 1'b0);
      quiet("fetch_10b", 10, 0, 1'b1);
      quiet("jmp_9b", 10, 1, 1'b1);
    end
    drain();

    // ---- Program B: JMP 0x0013 truncation, reset in the middle of LD wait ----
    clear_rom();
    rom[0] = {OP_JMP, 16'h0013};
    rom[3] = {OP_LD,  16'h0002};
    do_reset();
    reset_state("reset_b", 1'b1);
    quiet("jmp_13", 0, 1, 1'b1);
    quiet("fetch_3_trunc", 3, 0, 1'b1);
    push("ld_exec_wait", 1'b0, 1'b0, 3, 1, 1, 0, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    push("ld_wait_rst",  1'b0, 1'b1, 3, 1, 1, 0, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    reset_state("after_mid_rst", 1'b1);     // late mem_ready must be ignored
    quiet("late_ready_exec", 0, 1, 1'b1);
    drain();

    // ---- Program C: pc wraps 15 -> 0 ----
    clear_rom();
    rom[0]  = {OP_JMP, 16'h000F};
    rom[15] = {OP_NOP, 16'h0000};
    do_reset();
    reset_state("reset_c", 1'b0);
    quiet("jmp_f", 0, 1, 1'b0);
    quiet("fetch_15", 15, 0, 1'b0);
    quiet("nop_15", 15, 1, 1'b0);
    quiet("wrap_0", 0, 0, 1'b0);
    drain();

    // ---- Program D: unknown opcode 0xFF at pc=4, then RST opcode ----
    clear_rom();
    rom[0] = {OP_JMP, 16'h0004};
    rom[4] = {8'hFF,  16'h0000};
    rom[5] = {OP_RST, 16'h0007};
    do_reset();
    reset_state("reset_d", 1'b1);
    quiet("jmp_4", 0, 1, 1'b1);
    quiet("fetch_4d", 4, 0, 1'b1);
    quiet("illegal_exec", 4, 1, 1'b1);
`ifdef SEQ_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++)
      push("halt_hold", 1'b1, 1'b0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    drain();
    do_reset();
    reset_state("halt_reset", 1'b1);
`else
    quiet("fetch_5d", 5, 0, 1'b1);
    quiet("rst_op_exec", 5, 1, 1'b1);
    quiet("rst_op_pc0", 0, 0, 1'b1);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net: the directed run is a few hundred cycles
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute controller for the accumulator CPU.
- Owns the program counter and drives the instruction ROM address.
- Latches the 24-bit instruction word ({opcode[7:0], operand[15:0]}) and issues one-hot-style control strobes to the accumulator/ALU datapath and the data RAM.
- Sits between the instruction ROM, the data RAM and the accumulator datapath; it is the only master of the ROM address bus.

Parameters:
- PC_WIDTH, 4, program counter / ROM address width; program space 2**PC_WIDTH words.
- WORD_WIDTH, 24, instruction word width (8 opcode + 16 operand).
- DATA_ADDR_WIDTH, 16, data RAM address width (equals operand width).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  PC_WIDTH  instruction ROM address (= pc).
- rom_data  in  WORD_WIDTH  instruction word; combinational from ROM.
- mem_ready  in  1  data RAM handshake; access completes in a cycle where ram_req && mem_ready.
- ram_req  out  1  data RAM access request.
- ram_we  out  1  write qualifier, valid only with ram_req.
- ram_addr  out  DATA_ADDR_WIDTH  data RAM address (= IR operand).
- imm  out  16  immediate operand to the datapath.
- acc_we  out  1  accumulator write enable.
- acc_sel  out  2  accumulator source: 0 IMM, 1 RAM, 2 ALU.
- alu_op  out  2  ALU op: 0 PASS, 1 ADD (acc + ram_rdata), 2 INC (acc + 1).
- pc  out  PC_WIDTH  current program counter (debug).
- busy  out  1  high while not in FETCH.

Behaviour:
- Reset:
  - Synchronous, active-high; applies regardless of the current state, including mid-RAM-wait, which abandons the access.
  - Reset values: pc=0, IR=0, state=FETCH; ram_req, ram_we, acc_we and busy = 0; acc_sel=0, alu_op=0, imm=0, ram_addr=0.
- FSM: FETCH -> EXEC -> (MEM_WAIT) -> FETCH.
- FETCH:
  - rom_addr=pc; IR <= rom_data at the clock edge; next state EXEC.
  - All strobes are 0 in FETCH.
- EXEC (one cycle); strobes are combinational from IR and state:
  - NOP: no strobes; pc <= pc+1.
  - LDI: acc_we=1, acc_sel=IMM, imm=operand; pc+1.
  - INC: acc_we=1, acc_sel=ALU, alu_op=INC; pc+1.
  - JMP: pc <= operand[PC_WIDTH-1:0]; upper operand bits are ignored.
  - RST: pc <= 0; no datapath strobes.
  - LD, ADD, ST: ram_req=1, ram_addr=operand, ram_we=1 for ST only. If mem_ready is high this cycle the access completes in EXEC; otherwise go to MEM_WAIT.
- MEM_WAIT:
  - Hold ram_req, ram_we and ram_addr stable until mem_ready.
  - Completing cycle (EXEC or MEM_WAIT with mem_ready=1):
    - LD: acc_we=1, acc_sel=RAM.
    - ADD: acc_we=1, acc_sel=ALU, alu_op=ADD.
    - ST: no acc write.
  - Then pc+1 and go to FETCH.
- Latency: non-memory instruction 2 cycles; memory instruction 2 + N wait cycles.
- acc_we is asserted for exactly one cycle per LDI/INC/LD/ADD.
- PC wrap: pc+1 wraps modulo 2**PC_WIDTH (15 -> 0) with no flag.
- Unknown opcode: see Optional Feature.
- A mem_ready pulse outside a ram_req cycle is ignored.

Optional Feature:
- Macro SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in EXEC moves to the HALT state.
  - Extra output illegal_op (1 bit, reset 0) is set sticky.
  - No strobes are issued and pc freezes at the offending address.
  - busy=1 in HALT; only rst exits HALT.
- Undefined: an unknown opcode executes as NOP (pc+1), and there is no HALT state and no illegal_op port.

Decomposition:
- Opcode constants (NOP, LDI, ST, LD, ADD, INC, JMP, RST) live in the shared control instructions include, not in this block.
- Add to that shared file:
  - ACC_SEL_IMM/RAM/ALU
  - ALU_OP_PASS/ADD/INC
  - FSM state encodings
- One natural sub-module: instr_decode, the combinational mapping of opcode+state+mem_ready to strobes and next-pc select. The FSM and registers stay in instr_sequencer.

Test Plan:
- Reset then program [NOP, LDI 5] with mem_ready tied 1 -> rom_addr 0,0,1,1,2; acc_we pulses in cycle 4 with acc_sel=0, imm=5.
- ST 1 with mem_ready low for 3 cycles -> ram_req=1, ram_we=1, ram_addr=1 held 4 cycles; pc increments only after the ready cycle; acc_we stays 0.
- ADD 1, then LD 2, with mem_ready=1 -> ADD: acc_we with acc_sel=2, alu_op=1; LD: acc_we with acc_sel=1, ram_addr=2; each takes 2 cycles.
- JMP 9 at pc=10, then INC at 9 -> pc goes 10->9; INC issues acc_we, acc_sel=2, alu_op=2; repeats every 4 cycles. JMP 0x0013 with PC_WIDTH=4 -> pc=3.
- rst asserted during MEM_WAIT of LD 2 -> next cycle all outputs 0, pc=0, state FETCH; a later mem_ready produces no acc_we.
- Opcode 0xFF at pc=4 -> with SEQ_ILLEGAL_TRAP_EN: illegal_op=1, pc stays 4, busy=1 until rst. Without it: pc=5 after 2 cycles, no strobes.
